datapath: RTL and testbench
===========================

DATAPATH -- requirements
Module: datapath

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset; ports clock and clear.
REQ-002 clock  input  1  rising-edge clock for all registers.
REQ-003 clear  input  1  synchronous active-low reset; 0 at a rising edge resets all state.
REQ-004 Mdatain  input  32  memory read data.
REQ-005 Read  input  1  MDR source select: 1 = Mdatain, 0 = bus.
REQ-006 R0in..R15in  input  1 each  load register Rn from the bus.
REQ-007 R0_15_out  input  16  bit n drives Rn onto the bus.
REQ-008 PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cin  input  1 each  bus drive enables; Cin drives the sign-extended constant.
REQ-009 PCin, MARin, MDRin, IRin, Yin, HIin, LOin, Zhighin, Zlowin  input  1 each  register load enables.
REQ-010 IncPC  input  1  with PCin, increments PC.
REQ-011 opcode  input  5  ALU operation select.
REQ-012 BusMuxOut  output  32  current internal bus value, for observation.

Function
REQ-013 The state SHALL be: 32-bit R0-R15, PC, IR, MAR, MDR, Y, HI and LO; 64-bit Z, split into Zhigh and Zlow.
REQ-014 The bus SHALL be combinational, with this priority (first match wins):
- R0..R15 (lowest index first), then HI, LO, Zhigh, Zlow, PC, MDR, C.
- No enable asserted: bus = 0.
REQ-015 C SHALL be IR[18:0] sign-extended to 32 bits.
REQ-016 Loads SHALL take effect at the rising edge while the enable is high; several registers may load from the bus in the same cycle.
REQ-017 MDRin SHALL load MDR with Read ? Mdatain : bus.
REQ-018 PCin with IncPC SHALL load PC+1 (wrapping at 32 bits); PCin alone SHALL load the bus.
REQ-019 The ALU SHALL be combinational with A = Y and B = bus.
REQ-020 The ALU result SHALL be 64 bits; Zlowin loads result[31:0] into Zlow and Zhighin loads result[63:32] into Zhigh.
REQ-021 Opcode map, 32-bit results, high word 0 unless stated:
- 00011/01100 add: A+B.
- 00100 sub: A-B.
- 00101 shr: logical right shift of A by B[4:0].
- 00110 shra: arithmetic right shift.
- 00111 shl: left shift.
- 01000 ror, 01001 rol: rotates.
- 01010/01101 and, 01011/01110 or.
- 01111 mul: signed 64-bit product A*B.
- 10000 div: signed A/B, quotient low, remainder high; B=0 gives quotient 0, remainder A.
- 10001 neg: -B.
- 10010 not: ~B.
- All other opcodes: result = B, zero-extended.
REQ-022 Add and subtract SHALL wrap modulo 2^32 with no flags.
REQ-023 A shift or rotate count of 0 SHALL return A unchanged.

Reset
REQ-024 clear=0 at a rising edge SHALL zero every register, including R0-R15, PC, IR, MAR, MDR, Y, HI, LO and Z.
REQ-025 Reset SHALL take priority over all load enables in the same cycle.
REQ-026 While no bus-drive enable is asserted, BusMuxOut SHALL read 0, including after reset.

Verification
REQ-027 SHR: R2=0x19, R3=3, opcode 00101, R2out+Yin, then R3out+Zlowin, then Zlowout+R1in -> R1=0x00000003.
REQ-028 Register load path:
- Mdatain=0x18 with Read+MDRin -> MDR=0x18.
- Then MDRout+R1in -> R1=0x18 and BusMuxOut=0x18 during the transfer.
REQ-029 PCin+IncPC asserted three consecutive cycles after reset -> PC=3.
REQ-030 MUL: Y=0xFFFFFFFE, bus=3, opcode 01111, Zhighin+Zlowin -> Zhigh=0xFFFFFFFF, Zlow=0xFFFFFFFA.
REQ-031 Reset priority:
- clear=0 asserted while R1in is active -> R1=0.
- After release, IR=0x28918000 with Cin -> BusMuxOut=0x00018000.

Source files
------------

// File: rtl/datapath.sv
// datapath: shared 32-bit bus, sixteen general registers, special registers and a combinational 64-bit-result ALU
module datapath (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] Mdatain,
  input  logic        Read,
  input  logic        R0in,
  input  logic        R1in,
  input  logic        R2in,
  input  logic        R3in,
  input  logic        R4in,
  input  logic        R5in,
  input  logic        R6in,
  input  logic        R7in,
  input  logic        R8in,
  input  logic        R9in,
  input  logic        R10in,
  input  logic        R11in,
  input  logic        R12in,
  input  logic        R13in,
  input  logic        R14in,
  input  logic        R15in,
  input  logic [15:0] R0_15_out,
  input  logic        PCout,
  input  logic        Zhighout,
  input  logic        Zlowout,
  input  logic        MDRout,
  input  logic        HIout,
  input  logic        LOout,
  input  logic        Cin,
  input  logic        PCin,
  input  logic        MARin,
  input  logic        MDRin,
  input  logic        IRin,
  input  logic        Yin,
  input  logic        HIin,
  input  logic        LOin,
  input  logic        Zhighin,
  input  logic        Zlowin,
  input  logic        IncPC,
  input  logic [4:0]  opcode,
  output logic [31:0] BusMuxOut
);
  logic [31:0]        r_gpr [16];
  logic [31:0]        r_pc, r_ir, r_mar, r_mdr, r_y, r_hi, r_lo, r_zhi, r_zlo;
  logic [15:0]        w_rin;
  logic [31:0]        w_bus, w_c, w_a, w_b, w_quo, w_rem;
  logic signed [31:0] w_sq, w_sr, w_sra;
  logic [63:0]        w_res, w_prod, w_aa, w_ror, w_rol;
  logic [4:0]         w_sh;
  logic               w_ovf, w_unused;

  assign w_rin = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                  R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
  assign w_c = {{13{r_ir[18]}}, r_ir[18:0]};
  assign w_a = r_y;
  assign w_b = w_bus;
  assign w_sh = w_b[4:0];
  assign BusMuxOut = w_bus;
  // Rotates come from a doubled copy of A, so a zero count naturally yields A.
  assign w_aa = {w_a, w_a};
  assign w_ror = w_aa >> w_sh;
  assign w_rol = w_aa << w_sh;
  assign w_sra = $signed(w_a) >>> w_sh;
  // Sign-extended operands make the low 64 bits of an unsigned product the signed product.
  assign w_prod = {{32{w_a[31]}}, w_a} * {{32{w_b[31]}}, w_b};
  assign w_sq = $signed(w_a) / $signed(w_b);
  assign w_sr = $signed(w_a) % $signed(w_b);
  // Most-negative / -1 cannot be represented; pin it so the result never depends on the simulator.
  assign w_ovf = (w_a == 32'h8000_0000) && (w_b == 32'hFFFF_FFFF);
  assign w_quo = (w_b == '0) ? '0 : w_ovf ? w_a : w_sq;
  assign w_rem = (w_b == '0) ? w_a : w_ovf ? '0 : w_sr;
  assign w_unused = ^{r_mar, r_ir[31:19], w_ror[63:32], w_rol[31:0]};

  // Bus mux: apply sources from lowest to highest priority so the last match wins.
  always_comb begin
    w_bus = Cin ? w_c : '0;
    w_bus = MDRout ? r_mdr : w_bus;
    w_bus = PCout ? r_pc : w_bus;
    w_bus = Zlowout ? r_zlo : w_bus;
    w_bus = Zhighout ? r_zhi : w_bus;
    w_bus = LOout ? r_lo : w_bus;
    w_bus = HIout ? r_hi : w_bus;
    for (int i = 15; i >= 0; i--) w_bus = R0_15_out[i[3:0]] ? r_gpr[i[3:0]] : w_bus;
  end

  // ALU: A is Y, B is the bus; unlisted opcodes pass B through zero-extended.
  always_comb begin
    w_res = {32'h0, w_b};
    case (opcode)
      5'b00011, 5'b01100: w_res = {32'h0, w_a + w_b};
      5'b00100:           w_res = {32'h0, w_a - w_b};
      5'b00101:           w_res = {32'h0, w_a >> w_sh};
      5'b00110:           w_res = {32'h0, w_sra};
      5'b00111:           w_res = {32'h0, w_a << w_sh};
      5'b01000:           w_res = {32'h0, w_ror[31:0]};
      5'b01001:           w_res = {32'h0, w_rol[63:32]};
      5'b01010, 5'b01101: w_res = {32'h0, w_a & w_b};
      5'b01011, 5'b01110: w_res = {32'h0, w_a | w_b};
      5'b01111:           w_res = w_prod;
      5'b10000:           w_res = {w_rem, w_quo};
      5'b10001:           w_res = {32'h0, -w_b};
      5'b10010:           w_res = {32'h0, ~w_b};
      default:            w_res = {32'h0, w_b};
    endcase
  end

  // State registers: clear wins over every load; otherwise each enabled register captures its source.
  always_ff @(posedge clock) begin
    if (!clear) begin
      for (int i = 0; i < 16; i++) r_gpr[i[3:0]] <= '0;
      r_pc  <= '0;
      r_ir  <= '0;
      r_mar <= '0;
      r_mdr <= '0;
      r_y   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_zhi <= '0;
      r_zlo <= '0;
    end else begin
      for (int i = 0; i < 16; i++) if (w_rin[i[3:0]]) r_gpr[i[3:0]] <= w_bus;
      if (PCin)    r_pc  <= IncPC ? r_pc + 32'd1 : w_bus;
      if (IRin)    r_ir  <= w_bus;
      if (MARin)   r_mar <= w_bus;
      if (MDRin)   r_mdr <= Read ? Mdatain : w_bus;
      if (Yin)     r_y   <= w_bus;
      if (HIin)    r_hi  <= w_bus;
      if (LOin)    r_lo  <= w_bus;
      if (Zhighin) r_zhi <= w_res[63:32];
      if (Zlowin)  r_zlo <= w_res[31:0];
    end
  end
endmodule

// File: tb/tb_datapath.sv
// tb_datapath: directed vector table plus hand-written reset/immediate sequences, all observed through BusMuxOut
module tb_datapath;
  typedef struct {
    logic [95:0] n;
    logic [15:0] ro;
    logic [6:0]  d;
    logic [15:0] ri;
    logic [8:0]  l;
    logic [4:0]  op;
    logic        inc;
    logic        rd;
    logic [31:0] md;
    logic        cl;
    logic [31:0] e;
  } vec_t;

  localparam logic [15:0] R0 = 16'h0001, R1 = 16'h0002, R2 = 16'h0004, R3 = 16'h0008;
  localparam logic [6:0]  DPC = 7'h40, DZH = 7'h20, DZL = 7'h10, DMDR = 7'h08, DHI = 7'h04, DLO = 7'h02, DC = 7'h01;
  localparam logic [8:0]  LPC = 9'h100, LMDR = 9'h040, LIR = 9'h020, LY = 9'h010, LHI = 9'h008, LLO = 9'h004, LZH = 9'h002, LZL = 9'h001;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] Mdatain;
  logic        Read, IncPC;
  logic [15:0] rin, R0_15_out;
  logic        PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cin;
  logic        PCin, MARin, MDRin, IRin, Yin, HIin, LOin, Zhighin, Zlowin;
  logic [4:0]  opcode;
  logic [31:0] BusMuxOut;
  int          checks = 0;
  int          errors = 0;
  vec_t        tbl[$];

  datapath dut (
    .clock(clock), .clear(clear), .Mdatain(Mdatain), .Read(Read),
    .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
    .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
    .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .R0_15_out(R0_15_out), .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .MDRout(MDRout), .HIout(HIout), .LOout(LOout), .Cin(Cin),
    .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .HIin(HIin), .LOin(LOin), .Zhighin(Zhighin), .Zlowin(Zlowin),
    .IncPC(IncPC), .opcode(opcode), .BusMuxOut(BusMuxOut)
  );

  always #5 clock = ~clock;

  function automatic vec_t v(logic [95:0] n, logic [15:0] ro, logic [6:0] d, logic [15:0] ri, logic [8:0] l,
                             logic [4:0] op, logic inc, logic rd, logic [31:0] md, logic r, logic [31:0] e);
    vec_t t;
    t.n = n; t.ro = ro; t.d = d; t.ri = ri; t.l = l; t.op = op;
    t.inc = inc; t.rd = rd; t.md = md; t.cl = ~r; t.e = e;
    return t;
  endfunction

  function automatic vec_t mem(logic [95:0] n, logic [31:0] md);
    return v(n, '0, '0, '0, LMDR, '0, '0, '1, md, '0, '0);
  endfunction

  function automatic vec_t alu(logic [95:0] n, logic [15:0] ro, logic [4:0] op, logic [8:0] l, logic [31:0] e);
    return v(n, ro, '0, '0, l, op, '0, '0, '0, '0, e);
  endfunction

  function automatic vec_t out(logic [95:0] n, logic [6:0] d, logic [31:0] e);
    return v(n, '0, d, '0, '0, '0, '0, '0, '0, '0, e);
  endfunction

  function automatic vec_t pcinc(logic [95:0] n);
    return v(n, '0, '0, '0, LPC, '0, '1, '0, '0, '0, '0);
  endfunction

  task automatic apply(input vec_t t);
    R0_15_out = t.ro;
    {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cin} = t.d;
    rin = t.ri;
    {PCin, MARin, MDRin, IRin, Yin, HIin, LOin, Zhighin, Zlowin} = t.l;
    opcode = t.op;
    IncPC = t.inc;
    Read = t.rd;
    Mdatain = t.md;
    clear = t.cl;
    @(negedge clock);
    checks++;
    if (BusMuxOut !== t.e) begin
      errors++;
      $display("FAIL %s: BusMuxOut=%h expected %h", t.n, BusMuxOut, t.e);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    tbl.push_back(v("rst", '0, '0, '0, '0, '0, '0, '0, '0, '1, '0));
    tbl.push_back(alu("rst_r0", 16'hFFFF, '0, '0, '0));
    tbl.push_back(out("rst_hi", DHI, '0));
    tbl.push_back(out("rst_z", DZH | DZL, '0));
    tbl.push_back(out("rst_pcmdr", DPC | DMDR, '0));
    tbl.push_back(out("rst_c", DC, '0));
    tbl.push_back(out("idle", '0, '0));
    tbl.push_back(mem("mdr_rd", 32'h18));
    tbl.push_back(v("mdr_r1", '0, DMDR, R1, '0, '0, '0, '0, '0, '0, 32'h18));
    tbl.push_back(alu("r1", R1, '0, '0, 32'h18));
    tbl.push_back(mem("ld19", 32'h19));
    tbl.push_back(v("mdr_r2", '0, DMDR, R2, '0, '0, '0, '0, '0, '0, 32'h19));
    tbl.push_back(mem("ld3", 32'h3));
    tbl.push_back(v("mdr_r3", '0, DMDR, R3, '0, '0, '0, '0, '0, '0, 32'h3));
    tbl.push_back(alu("shr_y", R2, '0, LY, 32'h19));
    tbl.push_back(alu("shr_z", R3, 5'b00101, LZL, 32'h3));
    tbl.push_back(v("shr_r1", '0, DZL, R1, '0, '0, '0, '0, '0, '0, 32'h3));
    tbl.push_back(alu("shr_res", R1, '0, '0, 32'h3));
    tbl.push_back(alu("pri_r123", R1 | R2 | R3, '0, '0, 32'h3));
    tbl.push_back(v("pri_r2mdr", R2, DMDR, '0, '0, '0, '0, '0, '0, '0, 32'h19));
    tbl.push_back(out("pri_mdrc", DMDR | DC, 32'h3));
    tbl.push_back(pcinc("pc_inc1"));
    tbl.push_back(pcinc("pc_inc2"));
    tbl.push_back(pcinc("pc_inc3"));
    tbl.push_back(out("pc3", DPC, 32'h3));
    tbl.push_back(mem("ldfe", 32'hFFFF_FFFE));
    tbl.push_back(v("y_fe", '0, DMDR, '0, LY, '0, '0, '0, '0, '0, 32'hFFFF_FFFE));
    tbl.push_back(alu("mul", R1, 5'b01111, LZH | LZL, 32'h3));
    tbl.push_back(out("mul_hi", DZH, 32'hFFFF_FFFF));
    tbl.push_back(out("mul_lo", DZL, 32'hFFFF_FFFA));
    tbl.push_back(out("pri_zhzl", DZH | DZL, 32'hFFFF_FFFF));
    tbl.push_back(alu("add", R1, 5'b00011, LZH | LZL, 32'h3));
    tbl.push_back(out("add_lo", DZL, 32'h1));
    tbl.push_back(out("add_hi", DZH, 32'h0));
    tbl.push_back(alu("sub", R2, 5'b00100, LZL, 32'h19));
    tbl.push_back(out("sub_lo", DZL, 32'hFFFF_FFE5));
    tbl.push_back(mem("ldf9", 32'hFFFF_FFF9));
    tbl.push_back(v("y_f9", '0, DMDR, '0, LY, '0, '0, '0, '0, '0, 32'hFFFF_FFF9));
    tbl.push_back(alu("div", R3, 5'b10000, LZH | LZL, 32'h3));
    tbl.push_back(out("div_quo", DZL, 32'hFFFF_FFFE));
    tbl.push_back(out("div_rem", DZH, 32'hFFFF_FFFF));
    tbl.push_back(alu("div0", R0, 5'b10000, LZH | LZL, 32'h0));
    tbl.push_back(out("div0_quo", DZL, 32'h0));
    tbl.push_back(out("div0_rem", DZH, 32'hFFFF_FFF9));
    tbl.push_back(alu("rol", R1, 5'b01001, LZL, 32'h3));
    tbl.push_back(out("rol_res", DZL, 32'hFFFF_FFCF));
    tbl.push_back(alu("ror", R1, 5'b01000, LZL, 32'h3));
    tbl.push_back(out("ror_res", DZL, 32'h3FFF_FFFF));
    tbl.push_back(alu("shra", R1, 5'b00110, LZL, 32'h3));
    tbl.push_back(out("shra_res", DZL, 32'hFFFF_FFFF));
    tbl.push_back(alu("shl", R1, 5'b00111, LZL, 32'h3));
    tbl.push_back(out("shl_res", DZL, 32'hFFFF_FFC8));
    tbl.push_back(alu("ror0", R0, 5'b01000, LZL, 32'h0));
    tbl.push_back(out("ror0_res", DZL, 32'hFFFF_FFF9));
    tbl.push_back(alu("neg", R1, 5'b10001, LZL, 32'h3));
    tbl.push_back(out("neg_res", DZL, 32'hFFFF_FFFD));
    tbl.push_back(alu("shr0", R0, 5'b00101, LZL, 32'h0));
    tbl.push_back(out("shr0_res", DZL, 32'hFFFF_FFF9));
    tbl.push_back(alu("not", R1, 5'b10010, LZL, 32'h3));
    tbl.push_back(out("not_res", DZL, 32'hFFFF_FFFC));
    tbl.push_back(alu("and", R1, 5'b01010, LZL, 32'h3));
    tbl.push_back(out("and_res", DZL, 32'h1));
    tbl.push_back(alu("or", R1, 5'b01011, LZL, 32'h3));
    tbl.push_back(out("or_res", DZL, 32'hFFFF_FFFB));
    tbl.push_back(alu("and2", R1, 5'b01101, LZL, 32'h3));
    tbl.push_back(out("and2_res", DZL, 32'h1));
    tbl.push_back(alu("add2", R1, 5'b01100, LZL, 32'h3));
    tbl.push_back(out("add2_res", DZL, 32'hFFFF_FFFC));
    tbl.push_back(alu("or2", R1, 5'b01110, LZL, 32'h3));
    tbl.push_back(out("or2_res", DZL, 32'hFFFF_FFFB));
    tbl.push_back(alu("dflt", R1, 5'b00000, LZH | LZL, 32'h3));
    tbl.push_back(out("dflt_lo", DZL, 32'h3));
    tbl.push_back(out("dflt_hi", DZH, 32'h0));
    tbl.push_back(alu("hilo", R2, '0, LHI | LLO, 32'h19));
    tbl.push_back(out("hi", DHI, 32'h19));
    tbl.push_back(out("lo", DLO, 32'h19));
    tbl.push_back(alu("lo3", R3, '0, LLO, 32'h3));
    tbl.push_back(out("pri_hilo", DHI | DLO, 32'h19));
    tbl.push_back(out("lo3_res", DLO, 32'h3));
    tbl.push_back(alu("pc_ld", R2, '0, LPC, 32'h19));
    tbl.push_back(out("pc_19", DPC, 32'h19));
    tbl.push_back(pcinc("pc_inc4"));
    tbl.push_back(out("pc_1a", DPC, 32'h1A));
    tbl.push_back(v("mdr_bus", R3, '0, '0, LMDR, '0, '0, '0, 32'hDEAD_BEEF, '0, 32'h3));
    tbl.push_back(out("mdr_bus_res", DMDR, 32'h3));
    tbl.push_back(mem("ldff", 32'hFFFF_FFFF));
    tbl.push_back(v("pc_ff", '0, DMDR, '0, LPC, '0, '0, '0, '0, '0, 32'hFFFF_FFFF));
    tbl.push_back(pcinc("pc_wrap"));
    tbl.push_back(out("pc_wrap_res", DPC, 32'h0));

    foreach (tbl[i]) apply(tbl[i]);

    apply(v("clr_pri", R2, '0, R1, '0, '0, '0, '0, '0, '1, 32'h19));
    apply(alu("clr_r1", R1, '0, '0, 32'h0));
    apply(alu("clr_r2", R2, '0, '0, 32'h0));
    apply(out("clr_z", DZH | DZL, 32'h0));
    apply(out("clr_hilo", DHI | DLO, 32'h0));
    apply(out("clr_pc", DPC, 32'h0));
    apply(mem("ir_md", 32'h2891_8000));
    apply(v("ir_ld", '0, DMDR, '0, LIR, '0, '0, '0, '0, '0, 32'h2891_8000));
    apply(out("c_pos", DC, 32'h0001_8000));
    apply(mem("ir_md2", 32'h0004_0001));
    apply(v("ir_ld2", '0, DMDR, '0, LIR, '0, '0, '0, '0, '0, 32'h0004_0001));
    apply(out("c_neg", DC, 32'hFFFC_0001));
    apply(out("pri_mdr_c", DMDR | DC, 32'h0004_0001));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
